inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit for the RV32I core. It owns the program counter and issues word reads to instruction memory over a request/grant/response interface. It buffers returned instructions with their addresses and presents them to the decode stage through a valid/ready handshake. Redirects from the execute stage flush all buffered and in-flight fetches.

## Interface

**Parameters**
- `RESET_PC`, 32'h0000_0000, PC after reset.
- `DEPTH`, 2, entries in the instruction buffer; also the maximum number of outstanding requests (power of two, ≥2).

**Ports**
- `i_clk` in 1: core clock; everything is sampled on the rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `o_mem_req` out 1: fetch request valid.
- `o_mem_addr` out 32: fetch address, word aligned.
- `i_mem_gnt` in 1: request accepted this cycle.
- `i_mem_rvalid` in 1: response valid; responses return in order, ≥1 cycle after grant.
- `i_mem_rdata` in 32: fetched instruction word.
- `i_jump_flag` in 1: redirect pulse from ex.
- `i_jump_addr` in 32: redirect target.
- `o_inst_valid` out 1: instruction available to decode.
- `o_inst` out 32: instruction; `INST_NOP` when not valid.
- `o_inst_addr` out 32: address of `o_inst`.
- `i_id_ready` in 1: decode accepts `o_inst` this cycle.
- `o_misalign` out 1: one-cycle pulse when `i_jump_addr[1:0]` is nonzero.

## Operation

- **PC register**
  - Reset value is `RESET_PC`; `o_mem_addr` equals the PC.
  - Each grant (`o_mem_req & i_mem_gnt`) advances the PC by 4, wrapping modulo 2^32.
- **Request issue**
  - `o_mem_req` is asserted when state is RUN and `outstanding + buffer_count < DEPTH`.
  - This guarantees every response has a buffer slot, so the memory side needs no backpressure.
- **Pending-address queue**
  - Each grant pushes the granted PC into a queue of depth `DEPTH`.
  - Each accepted response pops the queue and pairs the popped address with `i_mem_rdata`.
- **Instruction buffer**
  - A synchronous FIFO of {inst, addr}.
  - It pushes on a kept `i_mem_rvalid` and pops on `o_inst_valid & i_id_ready`.
  - Push and pop in the same cycle is allowed; when full, a simultaneous push and pop is allowed.
- **Redirect** (`i_jump_flag` = 1)
  - The PC loads `{i_jump_addr[31:2], 2'b00}`.
  - `o_misalign` pulses the next cycle if `i_jump_addr[1:0]` is nonzero.
  - The buffer and pending queue are cleared.
  - The discard counter loads the number of requests still in flight, including a request granted in this same cycle.
  - An `i_mem_rvalid` arriving in the redirect cycle is dropped and is subtracted from the count.
  - State moves to DRAIN if the resulting count is nonzero, else stays in RUN.
- **State machine**
  - RUN: normal issue.
  - DRAIN: no requests are issued; each `i_mem_rvalid` is dropped and decrements the discard counter. At zero the next state is RUN.
  - A new `i_jump_flag` in DRAIN reloads the PC and stays in DRAIN with the same discard count.
- **Outputs**
  - `o_inst_valid` is high exactly when the buffer is non-empty.
  - `o_inst` and `o_inst_addr` show the buffer head.
  - `o_inst` is driven to `INST_NOP` (32'h0000_0013) when the buffer is empty.

## Timing

- **Reset values:**
  - `o_mem_req`=0
  - `o_mem_addr`=`RESET_PC`
  - `o_inst_valid`=0
  - `o_inst`=32'h0000_0013
  - `o_inst_addr`=0
  - `o_misalign`=0
  - state=RUN, counters=0
- **Startup:** the first `o_mem_req` goes high in the first cycle after `i_rst_n` deasserts.
- **Latency:** an `i_mem_rvalid` sampled at edge N gives `o_inst_valid` high after edge N, i.e. one registered stage.
- **Throughput:** with a one-cycle memory and `i_id_ready` held high, one instruction per cycle.
- **Redirect cost:**
  - `o_inst_valid` is 0 in the cycle after `i_jump_flag`.
  - A request to the target is issued in the cycle after the redirect if nothing is in flight.
  - Otherwise the request is issued in the cycle after the last discarded response.
- **Decode backpressure:** the buffer fills, then `o_mem_req` drops. No instruction is lost or duplicated.
- **Mid-operation reset:** reset asserted at any point returns all state to reset values at the next edge. Responses still in flight afterwards are the memory model's responsibility; the bench resets the memory too.

## Structure

- **Shared constants** go in `rv32i.v` alongside the opcode defines:
  - `INST_NOP` (32'h0000_0013)
  - `INST_ADDR_BUS`
  - `INST_BUS`
- **Sub-module** `fetch_fifo`: a parameterized synchronous FIFO (width, depth), with full/empty/count outputs and a synchronous flush input. It is instantiated twice: once for the pending-address queue and once for the instruction buffer.

## Test plan

- **Reset and streaming:** reset with `RESET_PC`=0x100, 1-cycle memory, `i_id_ready`=1 → `o_inst_addr` sequence 0x100, 0x104, 0x108, …, one per cycle, `o_inst` equal to the memory contents.
- **Decode stall:** `i_id_ready`=0 for 5 cycles → `o_mem_req` drops after 2 grants, `o_inst` holds the 0x100 word. On release, 0x100 and 0x104 are delivered in order, no gaps or duplicates.
- **Redirect with 2 requests in flight (3-cycle memory):** `i_jump_flag`, addr 0x200 → both stale responses dropped, next `o_inst_addr`=0x200.
- **Redirect coinciding with grant and rvalid:** the granted request is discarded, the rvalid is dropped, and the first valid output is the target instruction.
- **Misaligned target and wrap:** `i_jump_addr`=0x0000_0302 → `o_misalign` pulse, fetch from 0x300. Jump to 0xFFFF_FFFC → next fetch address is 0x0000_0000.
- **Reset in DRAIN:** assert reset while in DRAIN → all outputs at reset values next cycle, then fetch restarts from `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch unit.
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_BUS      = 32;
    localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [INST_BUS-1:0]      inst;
        logic [INST_ADDR_BUS-1:0] addr;
    } inst_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with count/full/empty status and a synchronous flush.
module fetch_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues word reads, buffers responses for decode and
// discards in-flight fetches after a redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned              DEPTH    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic                     o_mem_req,
    output logic [INST_ADDR_BUS-1:0] o_mem_addr,
    input  logic                     i_mem_gnt,
    input  logic                     i_mem_rvalid,
    input  logic [INST_BUS-1:0]      i_mem_rdata,
    input  logic                     i_jump_flag,
    input  logic [INST_ADDR_BUS-1:0] i_jump_addr,
    output logic                     o_inst_valid,
    output logic [INST_BUS-1:0]      o_inst,
    output logic [INST_ADDR_BUS-1:0] o_inst_addr,
    input  logic                     i_id_ready,
    output logic                     o_misalign
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthOcc = DEPTH[CntW:0];

    fetch_state_e             state_q;
    logic [INST_ADDR_BUS-1:0] pc_q;
    logic [CntW-1:0]          discard_q;
    logic                     misalign_q;

    logic                     grant, keep;
    logic [CntW:0]            occupancy;
    logic [CntW-1:0]          in_flight, drain_left;

    logic [INST_ADDR_BUS-1:0] pend_addr;
    logic                     pend_full, pend_empty;
    logic [CntW-1:0]          pend_cnt;
    inst_entry_t              buf_wdata, buf_head;
    logic                     buf_full, buf_empty;
    logic [CntW-1:0]          buf_cnt;

    always_comb begin
        occupancy = {1'b0, pend_cnt} + {1'b0, buf_cnt};
        // Every granted request has a reserved buffer slot, so responses never stall.
        o_mem_req = i_rst_n & (state_q == StRun) & (occupancy < DepthOcc)
                  & ~pend_full & ~buf_full;
        grant      = o_mem_req & i_mem_gnt;
        keep       = i_mem_rvalid & (state_q == StRun) & ~i_jump_flag & ~pend_empty;
        in_flight  = pend_cnt + CntW'(grant) - CntW'(i_mem_rvalid);
        drain_left = discard_q - CntW'(i_mem_rvalid);
        buf_wdata  = '{inst: i_mem_rdata, addr: pend_addr};
    end

    fetch_fifo #(
        .Width (INST_ADDR_BUS),
        .Depth (DEPTH)
    ) u_pend_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_jump_flag),
        .push_i  (grant),
        .wdata_i (pc_q),
        .pop_i   (keep),
        .rdata_o (pend_addr),
        .full_o  (pend_full),
        .empty_o (pend_empty),
        .count_o (pend_cnt)
    );

    fetch_fifo #(
        .Width ($bits(inst_entry_t)),
        .Depth (DEPTH)
    ) u_inst_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_jump_flag),
        .push_i  (keep),
        .wdata_i (buf_wdata),
        .pop_i   (o_inst_valid & i_id_ready),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            discard_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= i_jump_flag & (|i_jump_addr[1:0]);
            if (i_jump_flag) begin
                pc_q <= {i_jump_addr[INST_ADDR_BUS-1:2], 2'b00};
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end
            unique case (state_q)
                StRun: begin
                    if (i_jump_flag) begin
                        discard_q <= in_flight;
                        state_q   <= (in_flight != '0) ? StDrain : StRun;
                    end
                end
                StDrain: begin
                    // A redirect here only moves the PC; the stale count is unchanged.
                    discard_q <= drain_left;
                    if (drain_left == '0) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign o_mem_addr   = pc_q;
    assign o_inst_valid = ~buf_empty;
    assign o_inst       = buf_empty ? INST_NOP : buf_head.inst;
    assign o_inst_addr  = buf_head.addr;
    assign o_misalign   = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: epoch-tagged request model plus output scoreboard.
module tb_inst_fetch;

    localparam logic [31:0] ResetPc = 32'h0000_0100;
    localparam int          Depth   = 2;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        i_jump_flag = 1'b0;
    logic [31:0] i_jump_addr = '0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_addr;
    logic        i_id_ready = 1'b0;
    logic        o_misalign;

    inst_fetch #(
        .RESET_PC (ResetPc),
        .DEPTH    (Depth)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .i_jump_flag  (i_jump_flag),
        .i_jump_addr  (i_jump_addr),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_addr  (o_inst_addr),
        .i_id_ready   (i_id_ready),
        .o_misalign   (o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int epoch;} pend_t;
    typedef struct {logic [31:0] addr; logic [31:0] inst;} out_t;
    typedef struct {logic [31:0] data; int due;} mresp_t;

    pend_t  pend_q[$];   // granted requests, tagged with the redirect epoch they belong to
    out_t   exp_q[$];    // instructions decode should still receive, in order
    mresp_t mem_q[$];    // memory responses scheduled by cycle

    int          checks = 0, errors = 0, cycle = 0, epoch = 0, last_due = 0;
    logic [31:0] model_pc = ResetPc;
    logic        exp_misalign = 1'b0;
    logic        rst_active = 1'b1;
    int          gnt_pct, ready_pct, jump_pct, lat_max, rst_pm;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cycle++;
        rst_active   = 1'b1;
        i_rst_n      = 1'b0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_jump_flag  = 1'b0;
        i_id_ready   = 1'b0;
        mem_q.delete();
        pend_q.delete();
        exp_q.delete();
        model_pc     = ResetPc;
        exp_misalign = 1'b0;
        last_due     = 0;
        @(negedge clk);
        cycle++;
        #1;
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_addr", o_mem_addr, ResetPc);
        check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_inst, Nop);
        check("rst_inst_addr", o_inst_addr, 32'd0);
        check("rst_misalign", 32'(o_misalign), 32'd0);
        i_rst_n    = 1'b1;
        rst_active = 1'b0;
        #1;
        check("startup_req", 32'(o_mem_req), 32'd1);
        check("startup_addr", o_mem_addr, ResetPc);
    endtask

    task automatic cycle_step();
        logic        grant, exp_req;
        int          lat, due, cur;
        logic [31:0] tgt;
        pend_t       p;
        @(negedge clk);
        cycle++;
        i_mem_gnt  = ($urandom_range(99) < gnt_pct);
        i_id_ready = ($urandom_range(99) < ready_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = $urandom();
        end
        i_jump_flag = ($urandom_range(99) < jump_pct);
        case ($urandom_range(3))
            0:       tgt = 32'h0000_0302;
            1:       tgt = 32'hFFFF_FFFC;
            2:       tgt = 32'h0000_0200 + ($urandom_range(63) << 2);
            default: tgt = $urandom();
        endcase
        i_jump_addr = tgt;
        #1;
        cur     = pend_q.size() - stale_count();
        exp_req = (stale_count() == 0) && (cur + exp_q.size() < Depth);
        check("mem_req", 32'(o_mem_req), 32'(exp_req));
        check("mem_addr", o_mem_addr, model_pc);
        check("misalign", 32'(o_misalign), 32'(exp_misalign));
        #2;
        grant        = o_mem_req & i_mem_gnt;
        exp_misalign = 1'b0;
        if (i_mem_rvalid && pend_q.size() > 0) begin
            p = pend_q.pop_front();
            if (p.epoch == epoch) exp_q.push_back('{p.addr, mem_word(p.addr)});
        end
        if (grant) begin
            lat      = $urandom_range(lat_max, 1);
            due      = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
            last_due = due;
            mem_q.push_back('{mem_word(o_mem_addr), due});
            pend_q.push_back('{model_pc, epoch});
            model_pc = model_pc + 32'd4;
        end
        if (i_jump_flag) begin
            exp_q.delete();
            epoch++;
            model_pc     = {i_jump_addr[31:2], 2'b00};
            exp_misalign = |i_jump_addr[1:0];
        end
    endtask

    task automatic run_phase(input int n, input int g, input int r, input int j,
                             input int l, input int rp);
        gnt_pct = g; ready_pct = r; jump_pct = j; lat_max = l; rst_pm = rp;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(999) < rst_pm) do_reset();
            else cycle_step();
        end
    endtask

    // Scoreboard: compare whatever the DUT presents to decode against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_active) begin
                check("inst_valid", 32'(o_inst_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() > 0) begin
                    check("inst", o_inst, exp_q[0].inst);
                    check("inst_addr", o_inst_addr, exp_q[0].addr);
                    if (o_inst_valid && i_id_ready) void'(exp_q.pop_front());
                end else if (!o_inst_valid) begin
                    check("inst_nop", o_inst, Nop);
                end
            end
        end
    end

    initial begin
        do_reset();
        run_phase(120, 100, 100, 0, 1, 0);
        run_phase(80, 100, 30, 0, 1, 0);
        run_phase(200, 70, 60, 5, 4, 0);
        // Reset while stale responses are still being discarded.
        gnt_pct = 100; ready_pct = 50; jump_pct = 30; lat_max = 4; rst_pm = 0;
        for (int i = 0; i < 60; i++) begin
            cycle_step();
            if (stale_count() > 0) break;
        end
        do_reset();
        run_phase(200, 80, 80, 8, 3, 10);
        run_phase(100, 100, 100, 3, 1, 0);
        run_phase(20, 0, 100, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
